pipe_phy_msgbus_responder: RTL and testbench

//  PHY-side responder for the PIPE 5.0 message bus. Parses MAC->PHY transactions on
//  M2P_MessageBus, holds the PHY register file (uncommitted-write buffer plus commit),
//  and returns read_completion / write_ack on P2M_MessageBus. Sits in the PHY model

---
 rtl/pipe_phy_msgbus_responder_if.sv | 36 +++
 rtl/pipe_phy_msgbus_responder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pipe_phy_msgbus_responder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_phy_msgbus_responder_if.sv
// Message-bus bundle between the MAC side and the PHY responder.
// Ports: M2P bus in; P2M bus, reg_wr_*, reg_file_flat, busy, err_pulse out.
interface pipe_phy_msgbus_responder_if #(
    parameter int NUM_REGS = 16
);
    logic [7:0]            M2P_MessageBus;
    logic [7:0]            P2M_MessageBus;
    logic                  reg_wr_en;
    logic [11:0]           reg_wr_addr;
    logic [7:0]            reg_wr_data;
    logic [8*NUM_REGS-1:0] reg_file_flat;
    logic                  busy;
    logic                  err_pulse;

    modport master (
        output M2P_MessageBus,
        input  P2M_MessageBus,
        input  reg_wr_en,
        input  reg_wr_addr,
        input  reg_wr_data,
        input  reg_file_flat,
        input  busy,
        input  err_pulse
    );

    modport slave (
        input  M2P_MessageBus,
        output P2M_MessageBus,
        output reg_wr_en,
        output reg_wr_addr,
        output reg_wr_data,
        output reg_file_flat,
        output busy,
        output err_pulse
    );
endinterface

// File: rtl/pipe_phy_msgbus_responder.sv
// PHY-side PIPE message-bus responder: parser, uncommitted buffer, reg file.
// Ports: PCLK, phy_reset (sync, active-high), bus (slave modport).
module pipe_phy_msgbus_responder #(
    parameter int NUM_REGS       = 16,
    parameter int UNCOMMIT_DEPTH = 4,
    parameter int ACK_DELAY      = 2
) (
    input  logic PCLK,
    input  logic phy_reset,
    pipe_phy_msgbus_responder_if.slave bus
);

    localparam int PW = (UNCOMMIT_DEPTH > 1) ? $clog2(UNCOMMIT_DEPTH) : 1;
    localparam int CW = $clog2(UNCOMMIT_DEPTH + 1);
    localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_WRU = 4'd1;
    localparam logic [3:0] CMD_WRC = 4'd2;
    localparam logic [3:0] CMD_RD  = 4'd3;

    localparam logic [7:0] RSP_RDC = 8'h40;
    localparam logic [7:0] RSP_ACK = 8'h50;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ADDR,
        P_DATA
    } pst_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_DRAIN,
        R_WAIT,
        R_HDR,
        R_DATA
    } rst_e;

    pst_e         pst_q, pst_d;
    logic [3:0]   cmd_q, cmd_d;
    logic [11:0]  addr_q, addr_d;

    rst_e         rs_q, rs_d;
    logic         isrd_q, isrd_d;
    logic [7:0]   rdata_q, rdata_d;
    logic [11:0]  cmt_addr_q, cmt_addr_d;
    logic [7:0]   cmt_data_q, cmt_data_d;
    logic [DW-1:0] dly_q, dly_d;

    logic [11:0]  buf_addr_q [UNCOMMIT_DEPTH];
    logic [11:0]  buf_addr_d [UNCOMMIT_DEPTH];
    logic [7:0]   buf_data_q [UNCOMMIT_DEPTH];
    logic [7:0]   buf_data_d [UNCOMMIT_DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [CW-1:0] fill_q, fill_d;

    logic [7:0]   regs_q [NUM_REGS];
    logic [7:0]   regs_d [NUM_REGS];

    logic [7:0]   p2m_q, p2m_d;
    logic         wen_q, wen_d;
    logic [11:0]  waddr_q, waddr_d;
    logic [7:0]   wdata_q, wdata_d;
    logic         err_q, err_d;

    logic [7:0]   m2p;
    logic [3:0]   m2p_cmd;
    logic         cpl;
    logic [11:0]  cpl_addr;
    logic [7:0]   rd_byte;

    assign m2p     = bus.M2P_MessageBus;
    assign m2p_cmd = m2p[7:4];

    // Register lookup for reads; unimplemented addresses read as zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cpl_addr == 12'(i)) begin
                rd_byte = regs_q[i];
            end
        end
    end

    always_comb begin
        pst_d      = pst_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        rs_d       = rs_q;
        isrd_d     = isrd_q;
        rdata_d    = rdata_q;
        cmt_addr_d = cmt_addr_q;
        cmt_data_d = cmt_data_q;
        dly_d      = dly_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        fill_d     = fill_q;
        regs_d     = regs_q;
        p2m_d      = 8'h00;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        cpl        = 1'b0;
        cpl_addr   = addr_q;

        // Byte parser: one byte per cycle, never stalls.
        unique case (pst_q)
            P_IDLE: begin
                unique case (1'b1)
                    (m2p_cmd == CMD_NOP): ;
                    (m2p_cmd == CMD_WRU) ||
                    (m2p_cmd == CMD_WRC) ||
                    (m2p_cmd == CMD_RD): begin
                        cmd_d        = m2p_cmd;
                        addr_d[11:8] = m2p[3:0];
                        pst_d        = P_ADDR;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            P_ADDR: begin
                addr_d[7:0] = m2p;
                cpl_addr    = {addr_q[11:8], m2p};
                if (cmd_q == CMD_RD) begin
                    cpl   = 1'b1;
                    pst_d = P_IDLE;
                end else begin
                    pst_d = P_DATA;
                end
            end
            P_DATA: begin
                cpl   = 1'b1;
                pst_d = P_IDLE;
            end
            default: pst_d = P_IDLE;
        endcase

        // Response / drain engine.
        unique case (rs_q)
            R_IDLE: ;
            R_DRAIN: begin
                wen_d = 1'b1;
                if (fill_q != '0) begin
                    waddr_d = buf_addr_q[rp_q];
                    wdata_d = buf_data_q[rp_q];
                    fill_d  = fill_q - CW'(1);
                    if (rp_q == PW'(UNCOMMIT_DEPTH - 1)) begin
                        rp_d = '0;
                    end else begin
                        rp_d = rp_q + PW'(1);
                    end
                end else begin
                    // Committed write goes last, after the buffer is empty.
                    waddr_d = cmt_addr_q;
                    wdata_d = cmt_data_q;
                    isrd_d  = 1'b0;
                    dly_d   = DW'(ACK_DELAY - 1);
                    rs_d    = R_WAIT;
                end
            end
            R_WAIT: begin
                if (dly_q == '0) begin
                    p2m_d = isrd_q ? RSP_RDC : RSP_ACK;
                    rs_d  = R_HDR;
                end else begin
                    dly_d = dly_q - DW'(1);
                end
            end
            R_HDR: begin
                if (isrd_q) begin
                    p2m_d = rdata_q;
                    rs_d  = R_DATA;
                end else begin
                    rs_d = R_IDLE;
                end
            end
            R_DATA: rs_d = R_IDLE;
            default: rs_d = R_IDLE;
        endcase

        // A finished transaction is only accepted when nothing is pending.
        if (cpl) begin
            if (rs_q != R_IDLE) begin
                err_d = 1'b1;
            end else begin
                unique case (1'b1)
                    (cmd_q == CMD_WRU): begin
                        if (fill_q == CW'(UNCOMMIT_DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            buf_addr_d[wp_q] = addr_q;
                            buf_data_d[wp_q] = m2p;
                            fill_d = fill_q + CW'(1);
                            if (wp_q == PW'(UNCOMMIT_DEPTH - 1)) begin
                                wp_d = '0;
                            end else begin
                                wp_d = wp_q + PW'(1);
                            end
                        end
                    end
                    (cmd_q == CMD_WRC): begin
                        cmt_addr_d = addr_q;
                        cmt_data_d = m2p;
                        rs_d       = R_DRAIN;
                    end
                    default: begin
                        rdata_d = rd_byte;
                        isrd_d  = 1'b1;
                        dly_d   = DW'(ACK_DELAY - 1);
                        rs_d    = R_WAIT;
                    end
                endcase
            end
        end

        // Out-of-range writes still pulse reg_wr_en but touch nothing.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wen_d && waddr_d == 12'(i)) begin
                regs_d[i] = wdata_d;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (phy_reset) begin
            pst_q      <= P_IDLE;
            cmd_q      <= 4'd0;
            addr_q     <= 12'd0;
            rs_q       <= R_IDLE;
            isrd_q     <= 1'b0;
            rdata_q    <= 8'h00;
            cmt_addr_q <= 12'd0;
            cmt_data_q <= 8'h00;
            dly_q      <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            fill_q     <= '0;
            p2m_q      <= 8'h00;
            wen_q      <= 1'b0;
            waddr_q    <= 12'd0;
            wdata_q    <= 8'h00;
            err_q      <= 1'b0;
            for (int i = 0; i < UNCOMMIT_DEPTH; i++) begin
                buf_addr_q[i] <= 12'd0;
                buf_data_q[i] <= 8'h00;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            pst_q      <= pst_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            rs_q       <= rs_d;
            isrd_q     <= isrd_d;
            rdata_q    <= rdata_d;
            cmt_addr_q <= cmt_addr_d;
            cmt_data_q <= cmt_data_d;
            dly_q      <= dly_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            fill_q     <= fill_d;
            p2m_q      <= p2m_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            regs_q     <= regs_d;
        end
    end

    assign bus.P2M_MessageBus = p2m_q;
    assign bus.reg_wr_en      = wen_q;
    assign bus.reg_wr_addr    = waddr_q;
    assign bus.reg_wr_data    = wdata_q;
    assign bus.err_pulse      = err_q;
    assign bus.busy           = (rs_q != R_IDLE);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign bus.reg_file_flat[8*g +: 8] = regs_q[g];
    end

endmodule

// File: tb/tb_pipe_phy_msgbus_responder.sv
// Scoreboard bench for pipe_phy_msgbus_responder: timed expected events
// per output stream, checked by a negedge monitor.
module tb_pipe_phy_msgbus_responder;

    logic PCLK = 1'b0;
    logic phy_reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    pipe_phy_msgbus_responder_if #(.NUM_REGS(16)) bus ();

    pipe_phy_msgbus_responder #(
        .NUM_REGS(16),
        .UNCOMMIT_DEPTH(4),
        .ACK_DELAY(2)
    ) dut (
        .PCLK(PCLK),
        .phy_reset(phy_reset),
        .bus(bus)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [11:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t wr_q[$];
    ev_t rsp_q[$];
    int  err_q[$];
    ev_t m_e;
    logic [7:0] exp_regs [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge PCLK) begin
        if (mon_en) begin
            if (wr_q.size() > 0 && wr_q[0].c == cyc) begin
                m_e = wr_q.pop_front();
                chk("wr_en", 32'(bus.reg_wr_en), 32'd1);
                chk("wr_addr", 32'(bus.reg_wr_addr), 32'(m_e.a));
                chk("wr_data", 32'(bus.reg_wr_data), 32'(m_e.d));
            end else begin
                chk("wr_en_idle", 32'(bus.reg_wr_en), 32'd0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].c == cyc) begin
                m_e = rsp_q.pop_front();
                chk("p2m", 32'(bus.P2M_MessageBus), 32'(m_e.d));
            end else begin
                chk("p2m_idle", 32'(bus.P2M_MessageBus), 32'd0);
            end
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                void'(err_q.pop_front());
                chk("err", 32'(bus.err_pulse), 32'd1);
            end else begin
                chk("err_idle", 32'(bus.err_pulse), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] b, output int t);
        @(negedge PCLK);
        bus.M2P_MessageBus = b;
        t = cyc + 1;
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, output int t);
        int x;
        send(b0, x);
        send(b1, x);
        send(b2, t);
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge PCLK);
            bus.M2P_MessageBus = 8'h00;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        quiet(2);
        while (bus.busy && k < 100) begin
            quiet(1);
            k++;
        end
        if (k == 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL busy_timeout @cyc %0d: busy stuck 1, need 0", cyc);
        end
        quiet(2);
    endtask

    function automatic void exp_wr(input int c, input logic [11:0] a,
                                   input logic [7:0] d);
        wr_q.push_back('{c, a, d});
    endfunction

    function automatic void exp_rsp(input int c, input logic [7:0] d);
        rsp_q.push_back('{c, 12'd0, d});
    endfunction

    function automatic logic [7:0] reg_at(input int i);
        logic [127:0] f;
        f = bus.reg_file_flat;
        return f[8*i +: 8];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1);
    end

    initial begin
        int t;
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        bus.M2P_MessageBus = 8'h00;
        repeat (2) @(negedge PCLK);
        chk("rst_p2m", 32'(bus.P2M_MessageBus), 32'd0);
        chk("rst_wr_en", 32'(bus.reg_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.reg_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.reg_wr_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err_pulse), 32'd0);
        chk("rst_regs_lo", bus.reg_file_flat[31:0], 32'd0);
        chk("rst_regs_hi", bus.reg_file_flat[127:96], 32'd0);
        phy_reset = 1'b0;
        mon_en = 1'b1;

        // T1: commit reg3, then reset in the middle of a DATA byte.
        send3(8'h20, 8'h03, 8'h77, t);
        exp_wr(t + 1, 12'h003, 8'h77);
        exp_rsp(t + 3, 8'h50);
        wait_idle();
        chk("t1_reg3_pre", 32'(reg_at(3)), 32'h77);
        send(8'h20, t);
        send(8'h05, t);
        @(negedge PCLK);
        phy_reset = 1'b1;
        bus.M2P_MessageBus = 8'hA5;
        @(negedge PCLK);
        bus.M2P_MessageBus = 8'h00;
        @(negedge PCLK);
        phy_reset = 1'b0;
        quiet(6);
        chk("t1_reg3_post", 32'(reg_at(3)), 32'h00);
        chk("t1_busy", 32'(bus.busy), 32'd0);

        // T2: committed write.
        send3(8'h20, 8'h05, 8'hA5, t);
        exp_wr(t + 1, 12'h005, 8'hA5);
        exp_rsp(t + 3, 8'h50);
        exp_regs[5] = 8'hA5;
        wait_idle();
        chk("t2_reg5", 32'(reg_at(5)), 32'hA5);

        // T3: uncommitted chain; buffered value invisible to reads.
        send3(8'h10, 8'h01, 8'h11, t);
        send(8'h30, t);
        send(8'h01, t);
        exp_rsp(t + 2, 8'h40);
        exp_rsp(t + 3, 8'h00);
        wait_idle();
        send3(8'h10, 8'h01, 8'h22, t);
        send3(8'h20, 8'h02, 8'h33, t);
        exp_wr(t + 1, 12'h001, 8'h11);
        exp_wr(t + 2, 12'h001, 8'h22);
        exp_wr(t + 3, 12'h002, 8'h33);
        exp_rsp(t + 5, 8'h50);
        exp_regs[1] = 8'h22;
        exp_regs[2] = 8'h33;
        wait_idle();
        chk("t3_reg1", 32'(reg_at(1)), 32'h22);
        chk("t3_reg2", 32'(reg_at(2)), 32'h33);

        // T4: reads, in range and out of range.
        send(8'h30, t);
        send(8'h05, t);
        exp_rsp(t + 2, 8'h40);
        exp_rsp(t + 3, 8'hA5);
        wait_idle();
        send(8'h30, t);
        send(8'hFF, t);
        exp_rsp(t + 2, 8'h40);
        exp_rsp(t + 3, 8'h00);
        wait_idle();

        // T5: overflow, then commit to an unimplemented address.
        send3(8'h10, 8'h06, 8'h61, t);
        send3(8'h10, 8'h07, 8'h71, t);
        send3(8'h10, 8'h08, 8'h81, t);
        send3(8'h10, 8'h09, 8'h91, t);
        send3(8'h10, 8'h0A, 8'hA1, t);
        err_q.push_back(t);
        send3(8'h20, 8'h20, 8'hBB, t);
        exp_wr(t + 1, 12'h006, 8'h61);
        exp_wr(t + 2, 12'h007, 8'h71);
        exp_wr(t + 3, 12'h008, 8'h81);
        exp_wr(t + 4, 12'h009, 8'h91);
        exp_wr(t + 5, 12'h020, 8'hBB);
        exp_rsp(t + 7, 8'h50);
        exp_regs[6] = 8'h61;
        exp_regs[7] = 8'h71;
        exp_regs[8] = 8'h81;
        exp_regs[9] = 8'h91;
        wait_idle();

        // T6: illegal commands, and a read while an ack is pending.
        send(8'h70, t);
        err_q.push_back(t);
        quiet(2);
        send(8'h40, t);
        err_q.push_back(t);
        quiet(2);
        send3(8'h20, 8'h04, 8'h44, t);
        exp_wr(t + 1, 12'h004, 8'h44);
        exp_rsp(t + 3, 8'h50);
        err_q.push_back(t + 2);
        exp_regs[4] = 8'h44;
        send(8'h30, t);
        send(8'h01, t);
        wait_idle();
        quiet(4);

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("final_reg%0d", i), 32'(reg_at(i)),
                32'(exp_regs[i]));
        end
        chk("sb_wr_left", 32'(wr_q.size()), 32'd0);
        chk("sb_rsp_left", 32'(rsp_q.size()), 32'd0);
        chk("sb_err_left", 32'(err_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
